// File: rtl/store_buffer.sv
// store_buffer: aligns SB/SH/SW data into byte lanes and queues them in a small FIFO that drains to the DM port.
module store_buffer #(
  parameter int DEPTH = 2,
  parameter logic [5:0] OP_SB = 6'd20,
  parameter logic [5:0] OP_SH = 6'd21,
  parameter logic [5:0] OP_SW = 6'd22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [5:0]  i_mnemonic,
  input  logic [31:0] i_ALUout,
  input  logic [31:0] i_rs2_data,
  input  logic        i_load_req,
  input  logic [31:0] i_load_addr,
  output logic        o_stall,
  output logic        o_load_hazard,
  output logic        o_misaligned,
  output logic        o_DM_CS,
  output logic [3:0]  o_DM_WEB,
  output logic [31:0] o_DM_A,
  output logic [31:0] o_DM_DI
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    web_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic is_sb, is_sh, is_sw, store_req, full, empty, push, drain, match;
  logic [31:0] wdata;
  logic [3:0]  wweb;
  assign is_sb = i_mnemonic == OP_SB;
  assign is_sh = i_mnemonic == OP_SH;
  assign is_sw = i_mnemonic == OP_SW;
  // misalignment is masked during reset so every output shows its reset value
  assign o_misaligned = !rst && i_valid && ((is_sh && i_ALUout[0]) || (is_sw && i_ALUout[1:0] != 2'b00));
  assign store_req = i_valid && (is_sb || is_sh || is_sw) && !o_misaligned;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign o_stall = store_req && full;
  assign push = store_req && !full;
  assign wdata = is_sb ? {4{i_rs2_data[7:0]}} : is_sh ? {2{i_rs2_data[15:0]}} : i_rs2_data;
  assign wweb  = is_sb ? ~(4'b0001 << i_ALUout[1:0]) : is_sh ? (i_ALUout[1] ? 4'b0011 : 4'b1100) : 4'b0000;
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      match = match | (valid_q[i] && addr_q[i] == i_load_addr[31:2]);
  end
  assign o_load_hazard = i_load_req && match;
  assign drain = !empty && (!i_load_req || o_load_hazard);
  assign o_DM_CS  = drain;
  assign o_DM_WEB = drain ? web_q[head] : 4'hF;
  assign o_DM_A   = drain ? {addr_q[head], 2'b00} : 32'd0;
  assign o_DM_DI  = drain ? data_q[head] : 32'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        web_q[i] <= 4'hF;
        data_q[i] <= '0;
      end
    end else begin
      if (drain) begin
        valid_q[head] <= 1'b0;
        head <= head + AW'(1);
      end
      if (push) begin
        addr_q[tail] <= i_ALUout[31:2];
        web_q[tail] <= wweb;
        data_q[tail] <= wdata;
        valid_q[tail] <= 1'b1;
        tail <= tail + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(drain);
    end
  end
endmodule
